// File: rtl/sar_adc_scanner.sv
// SAR ADC scan controller: drives an external R2R DAC and analog mux, reads
// back a comparator through a 2-FF synchroniser, and returns left-justified
// 16-bit results tagged with their channel over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a start pulse or continuous tick
// S_MUX    | mux switched to next channel, DAC at 0, analog settling
// S_TRIAL  | current bit set on the DAC, waiting for DAC/comparator settle
// S_DECIDE | last settle cycle: keep or clear the current bit
// S_OUTPUT | result registered, waiting for the consumer to take it
module sar_adc_scanner #(
    parameter int WIDTH             = 8,
    parameter int NUM_CHANNELS      = 4,
    parameter int CLOCK_FREQ        = 100_000_000,
    parameter int SAMPLING_FREQ     = 2_000,
    parameter int SETTLE_CYCLES     = 16,
    parameter int MUX_SETTLE_CYCLES = 32,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    start,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic                    comparator,
    output logic [CW-1:0]           mux_sel,
    output logic [WIDTH-1:0]        dac_out,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             data_out,
    output logic [CW-1:0]           data_channel,
    output logic                    overrun
);

    localparam int SAMPLE_PERIOD = CLOCK_FREQ / SAMPLING_FREQ;
    localparam int PW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMAX = (MUX_SETTLE_CYCLES > SETTLE_CYCLES) ? MUX_SETTLE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = $clog2(WIDTH);

    if (SAMPLE_PERIOD <= 0) begin : g_bad_period
        $error("sar_adc_scanner: CLOCK_FREQ/SAMPLING_FREQ must be > 0");
    end

    typedef enum logic [2:0] {S_IDLE, S_MUX, S_TRIAL, S_DECIDE, S_OUTPUT} state_t;

    state_t                  r_state, w_next;
    logic                    r_cmp_meta, r_cmp_sync;
    logic [PW-1:0]           r_period;
    logic [TW-1:0]           r_timer;
    logic [BW-1:0]           r_bit;
    logic [NUM_CHANNELS-1:0] r_mask;
    logic [CW-1:0]           r_mux_sel;
    logic [WIDTH-1:0]        r_dac;
    logic                    r_out_valid;
    logic [15:0]             r_data;
    logic [CW-1:0]           r_data_ch;
    logic                    r_overrun;

    logic                    w_tick, w_trig, w_xfer;
    logic [NUM_CHANNELS-1:0] w_src, w_rest;
    logic [CW-1:0]           w_pick;
    logic [WIDTH-1:0]        w_code;

    // Trial hold is SETTLE-1 cycles in TRIAL plus the single DECIDE cycle.
    localparam logic [TW-1:0] MUX_LOAD    = TW'(MUX_SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 2);

    assign w_tick = en && (r_period == '0);
    assign w_trig = (mode ? w_tick : start) && (channel_mask != '0);
    assign w_xfer = r_out_valid && out_ready;
    // In IDLE the first channel comes straight from the live mask being captured.
    assign w_src  = (r_state == S_IDLE) ? channel_mask : r_mask;

    // Lowest remaining channel and the mask left once it has been taken.
    always_comb begin
        w_pick = '0;
        for (int n = NUM_CHANNELS - 1; n >= 0; n--) begin
            if (w_src[n]) w_pick = CW'(n);
        end
        w_rest = w_src & ~(NUM_CHANNELS'(1) << w_pick);
    end

    // Trial code with the current bit resolved by the synced comparator.
    always_comb begin
        w_code = r_dac;
        if (!r_cmp_sync) w_code[r_bit] = 1'b0;
    end

    // Comparator synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmp_meta <= 1'b0;
            r_cmp_sync <= 1'b0;
        end else begin
            r_cmp_meta <= comparator;
            r_cmp_sync <= r_cmp_meta;
        end
    end

    // Free-running continuous-mode period down-counter, held in reload while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                r_period <= PW'(SAMPLE_PERIOD - 1);
        else if (!en)              r_period <= PW'(SAMPLE_PERIOD - 1);
        else if (r_period == '0)   r_period <= PW'(SAMPLE_PERIOD - 1);
        else                       r_period <= r_period - 1'b1;
    end

    // Sticky overrun: a continuous tick that finds a scan still in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                      r_overrun <= 1'b0;
        else if (!en)                                    r_overrun <= 1'b0;
        else if (mode && w_tick && (r_state != S_IDLE))  r_overrun <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic; disable overrides everything.
    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_trig) w_next = S_MUX;
                S_MUX:    if (r_timer == '0) w_next = S_TRIAL;
                S_TRIAL:  if (r_timer == '0) w_next = S_DECIDE;
                S_DECIDE: w_next = (r_bit == '0) ? S_OUTPUT : S_TRIAL;
                S_OUTPUT: if (w_xfer) w_next = (r_mask != '0) ? S_MUX : S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Datapath: mux select, settle timer, DAC code, result and handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer     <= '0;
            r_bit       <= '0;
            r_mask      <= '0;
            r_mux_sel   <= '0;
            r_dac       <= '0;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_data_ch   <= '0;
        end else if (!en) begin
            r_timer     <= '0;
            r_dac       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_xfer) r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_MUX) begin
                        r_mux_sel <= w_pick;
                        r_mask    <= w_rest;
                        r_timer   <= MUX_LOAD;
                        r_dac     <= '0;
                    end
                end
                S_MUX: begin
                    if (r_timer == '0) begin
                        r_timer <= SETTLE_LOAD;
                        r_bit   <= BW'(WIDTH - 1);
                        r_dac   <= {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_TRIAL: begin
                    if (r_timer != '0) r_timer <= r_timer - 1'b1;
                end
                S_DECIDE: begin
                    if (r_bit == '0) begin
                        r_dac       <= w_code;
                        r_out_valid <= 1'b1;
                        r_data      <= 16'(w_code) << (16 - WIDTH);
                        r_data_ch   <= r_mux_sel;
                    end else begin
                        r_dac   <= w_code | (WIDTH'(1) << (r_bit - 1'b1));
                        r_bit   <= r_bit - 1'b1;
                        r_timer <= SETTLE_LOAD;
                    end
                end
                S_OUTPUT: begin
                    if (w_xfer) begin
                        r_dac <= '0;
                        if (r_mask != '0) begin
                            r_mux_sel <= w_pick;
                            r_mask    <= w_rest;
                            r_timer   <= MUX_LOAD;
                        end
                    end
                end
                default: r_dac <= '0;
            endcase
        end
    end

    assign mux_sel      = r_mux_sel;
    assign dac_out      = r_dac;
    assign busy         = (r_state != S_IDLE);
    assign out_valid    = r_out_valid;
    assign data_out     = r_data;
    assign data_channel = r_data_ch;
    assign overrun      = r_overrun;

endmodule
